// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences the PLL reset, qualifies the asynchronous
// locked pin, and turns it into a clean system reset plus a ready flag.
// Failed acquisitions are retried a bounded number of times before a sticky
// fault; a loss of lock while running triggers a full re-sequence.
module pll_lock_supervisor #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 3,
    parameter int unsigned CNT_W         = 20
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [1:0] retry_count,
    output logic [7:0] loss_count
);

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } state_t;

    // Terminal counts for the shared cycle counter (last cycle of each state).
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRIES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       retry_d;
    logic [7:0]       loss_d;
    logic             sync_q1, locked_s;

    // Two-flop synchronizer bringing the asynchronous locked pin into refclk.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value; blocking here would collapse the two stages.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_q1  <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync_q1  <= pll_locked;
            locked_s <= sync_q1;
        end
    end

    // State, counter and status registers.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q     <= RESET_PLL;
            cnt_q       <= '0;
            retry_count <= '0;
            loss_count  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_count <= retry_d;
            loss_count  <= loss_d;
        end
    end

    // Next-state logic; relock_req outranks lock loss, locked_s outranks timeout.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can
        // leave it unassigned and infer a latch.
        state_d = state_q;
        retry_d = retry_count;
        loss_d  = loss_count;
        unique case (state_q)
            RESET_PLL: begin
                if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    if (retry_count == RETRY_MAX) begin
                        state_d = FAULT;
                    end else begin
                        retry_d = retry_count + 2'd1;
                        state_d = RESET_PLL;
                    end
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                    retry_d = '0;
                end
            end
            RUN: begin
                if (relock_req) begin
                    state_d = RESET_PLL;
                    retry_d = '0;
                end else if (!locked_s) begin
                    state_d = RESET_PLL;
                    if (loss_count != 8'hFF) loss_d = loss_count + 8'd1;
                end
            end
            FAULT: begin
                if (relock_req) begin
                    state_d = RESET_PLL;
                    retry_d = '0;
                end
            end
            default: state_d = RESET_PLL;
        endcase
    end

    // Shared counter: restarts on every state change. Its value is unused in
    // RUN and FAULT, so wrapping there is harmless.
    always_comb begin
        cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
    end

    // Moore output decode of the registered state.
    always_comb begin
        pll_rst = (state_q == RESET_PLL) || (state_q == FAULT);
        sys_rst = (state_q != RUN);
        ready   = (state_q == RUN);
        fault   = (state_q == FAULT);
    end

endmodule
